// File: rtl/s1_link.sv
// Serial register-bank link: transmits or receives eight 21-bit frames (3-bit address, 18-bit data) over sen/sd.
// Define S1_PARITY_EN to append a 22nd parity bit in TX and reject frames with a bad parity bit in RX.
module s1_link #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        updown,
  output logic        S1_done,
  output logic        RB1_RW,
  output logic [2:0]  RB1_A,
  output logic [17:0] RB1_D,
  input  logic [17:0] RB1_Q,
  inout  wire         sen,
  inout  wire         sd
);

`ifdef S1_PARITY_EN
  localparam int FRAME_LEN = 22;
`else
  localparam int FRAME_LEN = 21;
`endif

  // S_INIT: held in reset | T_*: transmit RB1 | R_*: receive into RB1
  typedef enum logic [3:0] {
    S_INIT, T_RD, T_LD, T_SH, T_GAP, T_DONE, R_WAIT, R_SH, R_WR, R_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_dir;
  logic [2:0]             r_k;
  logic [4:0]             r_bit;
  logic [3:0]             r_gap;
  logic [FRAME_LEN-1:0]   r_sh;

  logic                   w_abort;
  logic                   w_last_bit;
  logic                   w_par_ok;
  logic [FRAME_LEN-1:0]   w_rx_shift;
  logic [FRAME_LEN-1:0]   w_tx_word;
  logic                   w_drv;
  logic                   w_sen_o;
  logic                   w_sd_o;

  assign w_abort    = (r_state != S_INIT) && (updown != r_dir);
  assign w_last_bit = (r_bit == 5'd0);
  assign w_rx_shift = {r_sh[FRAME_LEN-2:0], sd};

`ifdef S1_PARITY_EN
  // Parity bit is the XNOR of address and data, so a good frame XORs to 1 overall.
  assign w_tx_word = {r_k, RB1_Q, ~^{r_k, RB1_Q}};
  assign w_par_ok  = ^w_rx_shift;
`else
  assign w_tx_word = {r_k, RB1_Q};
  assign w_par_ok  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = updown ? R_WAIT : T_RD;
    end else begin
      case (r_state)
        S_INIT: w_next = updown ? R_WAIT : T_RD;
        T_RD:   w_next = T_LD;
        T_LD:   w_next = T_SH;
        T_SH:   if (w_last_bit) w_next = T_GAP;
        T_GAP:  if (r_gap == 4'd0) w_next = (r_k == 3'd7) ? T_DONE : T_RD;
        T_DONE: w_next = T_DONE;
        R_WAIT: if (!sen) w_next = R_SH;
        R_SH: begin
          if (sen)             w_next = R_WAIT;
          else if (w_last_bit) w_next = w_par_ok ? R_WR : R_WAIT;
        end
        R_WR:   w_next = (r_k == 3'd7) ? R_DONE : R_WAIT;
        R_DONE: w_next = R_DONE;
        default: w_next = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir <= 1'b0;
      r_k   <= 3'd0;
      r_bit <= 5'd0;
      r_gap <= 4'd0;
      r_sh  <= '0;
    end else begin
      r_dir <= updown;
      if (w_abort || r_state == S_INIT) begin
        r_k   <= 3'd0;
        r_bit <= 5'd0;
        r_gap <= 4'd0;
        r_sh  <= '0;
      end else begin
        case (r_state)
          T_LD: begin
            r_sh  <= w_tx_word;
            r_bit <= 5'(FRAME_LEN - 1);
          end
          T_SH: begin
            r_sh <= r_sh << 1;
            if (w_last_bit) r_gap <= 4'(GAP_CYCLES - 1);
            else            r_bit <= r_bit - 5'd1;
          end
          T_GAP: begin
            if (r_gap != 4'd0)    r_gap <= r_gap - 4'd1;
            else if (r_k != 3'd7) r_k   <= r_k + 3'd1;
          end
          R_WAIT: begin
            if (!sen) begin
              r_sh  <= w_rx_shift;
              r_bit <= 5'(FRAME_LEN - 2);
            end
          end
          R_SH: begin
            if (!sen) begin
              r_sh <= w_rx_shift;
              if (!w_last_bit) r_bit <= r_bit - 5'd1;
            end
          end
          R_WR: if (r_k != 3'd7) r_k <= r_k + 3'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    S1_done = 1'b0;
    RB1_RW  = 1'b1;
    RB1_A   = 3'd0;
    RB1_D   = 18'd0;
    w_drv   = 1'b0;
    w_sen_o = 1'b1;
    w_sd_o  = 1'b0;
    case (r_state)
      T_RD: begin
        w_drv = 1'b1;
        RB1_A = r_k;
      end
      T_LD, T_GAP: w_drv = 1'b1;
      T_SH: begin
        w_drv   = 1'b1;
        w_sen_o = 1'b0;
        w_sd_o  = r_sh[FRAME_LEN-1];
      end
      T_DONE: begin
        w_drv   = 1'b1;
        S1_done = 1'b1;
      end
      R_WR: begin
        RB1_RW = 1'b0;
        RB1_A  = r_sh[FRAME_LEN-1 -: 3];
        RB1_D  = r_sh[FRAME_LEN-4 -: 18];
      end
      R_DONE: S1_done = 1'b1;
      default: ;
    endcase
  end

  // Released whenever not transmitting, including asynchronously in reset.
  assign sen = w_drv ? w_sen_o : 1'bz;
  assign sd  = w_drv ? w_sd_o  : 1'bz;

endmodule
